// File: rtl/alu_issue_unit.sv
// Command front end for the 4-bit ALU: a command FIFO, an issue register that drives the ALU,
// and a response register that captures result and flags behind a valid/ready handshake.
module alu_issue_unit #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_func,
    input  logic [3:0]              cmd_a,
    input  logic [3:0]              cmd_b,
    input  logic [TAGW-1:0]         cmd_tag,
    output logic [3:0]              alu_a,
    output logic [3:0]              alu_b,
    output logic [3:0]              alu_op,
    output logic                    alu_less,
    input  logic [3:0]              alu_result,
    input  logic                    alu_cout,
    input  logic                    alu_set,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [3:0]              rsp_result,
    output logic                    rsp_zero,
    output logic                    rsp_carry,
    output logic                    rsp_ovf,
    output logic                    rsp_err,
    output logic [TAGW-1:0]         rsp_tag,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 3 + 4 + 4 + TAGW;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b011;
    localparam logic [2:0] F_SLT = 3'b100;
    localparam logic [2:0] F_NOR = 3'b101;

    function automatic logic [3:0] decode_op(input logic [2:0] f);
        case (f)
            F_AND:   return 4'b0000;
            F_OR:    return 4'b0001;
            F_ADD:   return 4'b0010;
            F_SUB:   return 4'b0110;
            F_SLT:   return 4'b0111;
            F_NOR:   return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic add_ovf(input logic [3:0] a, input logic [3:0] b, input logic [3:0] r);
        return (a[3] == b[3]) && (r[3] != a[3]);
    endfunction

    function automatic logic sub_ovf(input logic [3:0] a, input logic [3:0] b, input logic [3:0] r);
        return (a[3] != b[3]) && (r[3] != a[3]);
    endfunction

    logic [EW-1:0]   fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_p0;
    logic [EW-1:0]   head_p0;
    logic            push, pop, s2_load;

    logic            vld_p1;
    logic [2:0]      func_p1;
    logic [3:0]      a_p1, b_p1, op_p1;
    logic [TAGW-1:0] tag_p1;

    logic            vld_p2, zero_p2, carry_p2, ovf_p2, err_p2;
    logic [3:0]      result_p2;
    logic [TAGW-1:0] tag_p2;

    logic [3:0]      res_c;
    logic            carry_c, ovf_c, err_c;

    assign cmd_ready = (count_p0 != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign s2_load   = vld_p1 && (!vld_p2 || rsp_ready);
    assign pop       = (count_p0 != '0) && (!vld_p1 || s2_load);
    assign head_p0   = fifo_mem[rd_ptr];

    // p0: command FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_p0 <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_p0 <= count_p0 + CW'(1);
                2'b01:   count_p0 <= count_p0 - CW'(1);
                default: count_p0 <= count_p0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_func, cmd_a, cmd_b, cmd_tag};
    end

    // p1: issue register, drives the ALU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            func_p1 <= '0;
            a_p1    <= '0;
            b_p1    <= '0;
            op_p1   <= '0;
            tag_p1  <= '0;
        end else if (pop) begin
            vld_p1                         <= 1'b1;
            {func_p1, a_p1, b_p1, tag_p1}  <= head_p0;
            op_p1                          <= decode_op(head_p0[EW-1 -: 3]);
        end else if (s2_load) begin
            vld_p1 <= 1'b0;
        end
    end

    assign alu_a    = a_p1;
    assign alu_b    = b_p1;
    assign alu_op   = op_p1;
    assign alu_less = 1'b0;

    // SLT ignores the ALU's upper bits; the sign of a-b is corrected for overflow here.
    always_comb begin
        res_c   = alu_result;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        err_c   = 1'b0;
        case (func_p1)
            F_AND, F_OR, F_NOR: begin
            end
            F_ADD: begin
                carry_c = alu_cout;
                ovf_c   = add_ovf(a_p1, b_p1, alu_result);
            end
            F_SUB: begin
                carry_c = alu_cout;
                ovf_c   = sub_ovf(a_p1, b_p1, alu_result);
            end
            F_SLT: begin
                res_c = {3'b000, alu_set ^ sub_ovf(a_p1, b_p1, {alu_set, 3'b000})};
            end
            default: begin
                res_c = 4'b0000;
                err_c = 1'b1;
            end
        endcase
    end

    // p2: response register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            zero_p2   <= 1'b0;
            carry_p2  <= 1'b0;
            ovf_p2    <= 1'b0;
            err_p2    <= 1'b0;
            tag_p2    <= '0;
        end else if (s2_load) begin
            vld_p2    <= 1'b1;
            result_p2 <= res_c;
            zero_p2   <= (res_c == 4'b0000);
            carry_p2  <= carry_c;
            ovf_p2    <= ovf_c;
            err_p2    <= err_c;
            tag_p2    <= tag_p1;
        end else if (rsp_ready) begin
            vld_p2 <= 1'b0;
        end
    end

    assign rsp_valid  = vld_p2;
    assign rsp_result = result_p2;
    assign rsp_zero   = zero_p2;
    assign rsp_carry  = carry_p2;
    assign rsp_ovf    = ovf_p2;
    assign rsp_err    = err_p2;
    assign rsp_tag    = tag_p2;
    assign fifo_count = count_p0;

endmodule
